// File: rtl/alu_defs_pkg.sv
// Shared ALU operation codes and the multiply/divide op predicate.
// Used by alu_mdu and alu_mdu_iter; ALU_OVERFLOW_EN lives in alu_mdu.
package alu_defs_pkg;

   typedef enum logic [4:0] {
      ADDU  = 5'd0,
      SUBU  = 5'd1,
      ADD   = 5'd2,
      SUB   = 5'd3,
      AND   = 5'd4,
      OR    = 5'd5,
      SLT   = 5'd6,
      SLL   = 5'd7,
      SRL   = 5'd8,
      SRA   = 5'd9,
      LUI   = 5'd10,
      EQL   = 5'd11,
      BNE   = 5'd12,
      MULT  = 5'd13,
      MULTU = 5'd14,
      DIV   = 5'd15,
      DIVU  = 5'd16,
      MFHI  = 5'd17,
      MFLO  = 5'd18,
      MTHI  = 5'd19,
      MTLO  = 5'd20
   } alu_op_e;

   function automatic logic is_mdu_op(input logic [4:0] op);
      return (op == MULT) || (op == MULTU) ||
             (op == DIV)  || (op == DIVU);
   endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Result is presented on res_hi/res_lo while wr is high.
module alu_mdu_iter
   import alu_defs_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             go,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             wr,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} st_e;

   st_e               st, st_n;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  acc, q, m;
   logic              isdiv, pneg, rneg, dz;
   logic              sgn, sa, sb, divop;
   logic [WIDTH-1:0]  ma, mb;
   logic [WIDTH:0]    sum, t;
   logic [WIDTH-1:0]  nacc, nq;
   logic [2*WIDTH-1:0] prod, prodc;

   assign sgn   = (op == MULT) || (op == DIV);
   assign divop = (op == DIV) || (op == DIVU);
   assign sa    = sgn & a[WIDTH-1];
   assign sb    = sgn & b[WIDTH-1];
   assign ma    = sa ? -a : a;
   assign mb    = sb ? -b : b;
   assign busy  = (st == RUN);
   assign wr    = (st == RUN) && (cnt == CW'(1));

   always_comb begin
      sum  = {1'b0, acc} + {1'b0, m & {WIDTH{q[0]}}};
      t    = {acc, q[WIDTH-1]} - {1'b0, m};
      nacc = acc;
      nq   = q;
      if (isdiv) begin
         if (!t[WIDTH]) begin
            nacc = t[WIDTH-1:0];
            nq   = {q[WIDTH-2:0], 1'b1};
         end else begin
            nacc = {acc[WIDTH-2:0], q[WIDTH-1]};
            nq   = {q[WIDTH-2:0], 1'b0};
         end
      end else begin
         nacc = sum[WIDTH:1];
         nq   = {sum[0], q[WIDTH-1:1]};
      end
   end

   // Divide by zero: all-ones quotient; remainder sign fix restores A.
   always_comb begin
      prod  = {nacc, nq};
      prodc = pneg ? -prod : prod;
      if (isdiv) begin
         res_hi = rneg ? -nacc : nacc;
         res_lo = dz ? '1 : (pneg ? -nq : nq);
      end else begin
         res_hi = prodc[2*WIDTH-1:WIDTH];
         res_lo = prodc[WIDTH-1:0];
      end
   end

   always_comb begin
      st_n = st;
      unique case (st)
         IDLE:    if (go) st_n = RUN;
         RUN:     if (wr) st_n = IDLE;
         default: st_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         st    <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         q     <= '0;
         m     <= '0;
         isdiv <= 1'b0;
         pneg  <= 1'b0;
         rneg  <= 1'b0;
         dz    <= 1'b0;
         done  <= 1'b0;
      end else begin
         st   <= st_n;
         done <= wr;
         if (st == IDLE && go) begin
            acc   <= '0;
            q     <= divop ? ma : mb;
            m     <= divop ? mb : ma;
            isdiv <= divop;
            pneg  <= sa ^ sb;
            rneg  <= sa;
            dz    <= (b == '0);
            cnt   <= CW'(WIDTH);
         end else if (st == RUN) begin
            acc <= nacc;
            q   <= nq;
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with HI/LO and iterative multiply/divide.
// ALU_OVERFLOW_EN builds signed ADD/SUB overflow detection.
module alu_mdu
   import alu_defs_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       ALUOp,
   input  logic             start,
   output logic [WIDTH-1:0] C,
   output logic             zero,
   output logic             overflow,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] sum, dif, r_hi, r_lo;
   logic [SHW-1:0]   sh;
   logic             wr, go, iscmp, cz;

   assign sh  = A[SHW-1:0];
   assign sum = A + B;
   assign dif = A - B;
   assign go  = start && is_mdu_op(ALUOp);

   alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rstn   (rstn),
      .go     (go),
      .op     (ALUOp),
      .a      (A),
      .b      (B),
      .busy   (busy),
      .done   (done),
      .wr     (wr),
      .res_hi (r_hi),
      .res_lo (r_lo)
   );

   always_comb begin
      C     = '0;
      iscmp = 1'b0;
      cz    = 1'b0;
      unique case (ALUOp)
         ADDU, ADD: C = sum;
         SUBU, SUB: C = dif;
         AND:  C = A & B;
         OR:   C = A | B;
         SLT:  C = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
         SLL:  C = B << sh;
         SRL:  C = B >> sh;
         SRA:  C = $unsigned($signed(B) >>> sh);
         LUI:  C = B << 16;
         MFHI: C = hi;
         MFLO: C = lo;
         EQL: begin
            iscmp = 1'b1;
            cz    = (A == B);
         end
         BNE: begin
            iscmp = 1'b1;
            cz    = (A != B);
         end
         default: C = '0;
      endcase
      zero = iscmp ? cz : (C == '0);
   end

`ifdef ALU_OVERFLOW_EN
   always_comb begin
      overflow = 1'b0;
      if (ALUOp == ADD)
         overflow = (A[WIDTH-1] == B[WIDTH-1]) &&
                    (sum[WIDTH-1] != A[WIDTH-1]);
      else if (ALUOp == SUB)
         overflow = (A[WIDTH-1] != B[WIDTH-1]) &&
                    (dif[WIDTH-1] != A[WIDTH-1]);
   end
`else
   assign overflow = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         hi <= '0;
         lo <= '0;
      end else if (wr) begin
         hi <= r_hi;
         lo <= r_lo;
      end else if (start && !busy && ALUOp == MTHI) begin
         hi <= A;
      end else if (start && !busy && ALUOp == MTLO) begin
         lo <= A;
      end
   end

endmodule
